rr_arb2: RTL and testbench

RR_ARB2 -- requirements
Module: rr_arb2

---
 rtl/rr_arb2.sv | 163 ++++++++++++++++
 tb/tb_rr_arb2.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter with hold-time limit and forced release.
// Latency: one cycle from req sampled at an edge to gnt visible after that edge.
// Backpressure: a holder keeps the grant until done/req drop, or until MAXHOLD cycles if the other side waits.
//
// Ports:
//   clk        sole clock, all state updates on its rising edge
//   reset      synchronous active-low reset
//   req[1:0]   request per requester
//   done[1:0]  release strobe, only looked at for the current holder
//   gnt[1:0]   registered one-hot-or-zero grant
//   gnt_valid  registered, equals gnt[0] | gnt[1]
//   gnt_id     index of current holder; keeps the last holder while idle
//   preempt    one-cycle pulse in the first cycle after a timeout release
module rr_arb2 #(
    parameter int MAXHOLD = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic [1:0] done,
    output logic [1:0] gnt,
    output logic       gnt_valid,
    output logic       gnt_id,
    output logic       preempt
);

    // State encoding equals the grant vector, so gnt comes straight off the
    // state register with no extra decode.
    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_GRANT0 = 2'b01;
    localparam logic [1:0] ST_GRANT1 = 2'b10;

    localparam logic [3:0] MAX_CNT = 4'(MAXHOLD);

    logic [1:0] r_state;
    logic [3:0] r_cnt;
    logic       r_last;
    logic       r_gnt_id;
    logic       r_gnt_valid;
    logic       r_preempt;

    logic [1:0] w_state_nxt;
    logic [3:0] w_cnt_nxt;
    logic       w_last_nxt;
    logic       w_gnt_id_nxt;
    logic       w_preempt_nxt;

    // Grant decision shared by every branch that hands the resource over.
    logic       w_take;
    logic       w_take_idx;

    logic       w_rel_norm;
    logic       w_rel_force;
    logic [3:0] w_cnt_inc;

    // Saturating increment of the hold counter.
    assign w_cnt_inc = (r_cnt >= MAX_CNT) ? MAX_CNT : (r_cnt + 4'd1);

    always_comb begin
        w_take      = 1'b0;
        w_take_idx  = 1'b0;
        w_rel_norm  = 1'b0;
        w_rel_force = 1'b0;
        w_preempt_nxt = 1'b0;
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;

        case (r_state)
            ST_IDLE: begin
                // On a tie the requester that did not win last time goes first.
                unique case (req)
                    2'b01: begin w_take = 1'b1; w_take_idx = 1'b0;    end
                    2'b10: begin w_take = 1'b1; w_take_idx = 1'b1;    end
                    2'b11: begin w_take = 1'b1; w_take_idx = ~r_last; end
                    default: begin w_take = 1'b0; w_take_idx = 1'b0;  end
                endcase
            end

            ST_GRANT0: begin
                // done[1] is never looked at here, so junk on it is harmless.
                w_rel_norm  = done[0] | ~req[0];
                w_rel_force = (r_cnt == MAX_CNT) & req[1];
                if (w_rel_norm) begin
                    // A normally released holder cannot be re-granted at this
                    // edge: either the other side takes over or we go idle.
                    if (req[1]) begin
                        w_take     = 1'b1;
                        w_take_idx = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = 4'd0;
                    end
                end else if (w_rel_force) begin
                    w_take        = 1'b1;
                    w_take_idx    = 1'b1;
                    w_preempt_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end

            ST_GRANT1: begin
                w_rel_norm  = done[1] | ~req[1];
                w_rel_force = (r_cnt == MAX_CNT) & req[0];
                if (w_rel_norm) begin
                    if (req[0]) begin
                        w_take     = 1'b1;
                        w_take_idx = 1'b0;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = 4'd0;
                    end
                end else if (w_rel_force) begin
                    w_take        = 1'b1;
                    w_take_idx    = 1'b0;
                    w_preempt_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end

            default: begin
                // Unreachable encoding: recover to idle.
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase

        // Any new grant restarts the hold count at 1 and records the winner.
        w_last_nxt   = r_last;
        w_gnt_id_nxt = r_gnt_id;
        if (w_take) begin
            w_state_nxt  = w_take_idx ? ST_GRANT1 : ST_GRANT0;
            w_cnt_nxt    = 4'd1;
            w_last_nxt   = w_take_idx;
            w_gnt_id_nxt = w_take_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_last      <= 1'b1;      // requester 0 wins the first tie
            r_gnt_id    <= 1'b0;
            r_gnt_valid <= 1'b0;
            r_preempt   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_last      <= w_last_nxt;
            r_gnt_id    <= w_gnt_id_nxt;
            r_gnt_valid <= (w_state_nxt != ST_IDLE);
            r_preempt   <= w_preempt_nxt;
        end
    end

    assign gnt       = r_state;
    assign gnt_valid = r_gnt_valid;
    assign gnt_id    = r_gnt_id;
    assign preempt   = r_preempt;

endmodule

// File: tb/tb_rr_arb2.sv
// Bench for rr_arb2: directed vectors, a cycle-level reference model and
// hand-computed literal expectations.
module tb_rr_arb2;

    localparam int MH = 4;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] req   = 2'b00;
    logic [1:0] done  = 2'b00;
    logic [1:0] gnt;
    logic       gnt_valid;
    logic       gnt_id;
    logic       preempt;

    rr_arb2 #(.MAXHOLD(MH)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id),
        .preempt   (preempt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    // Reference model: who holds the resource (-1 = nobody), how many cycles
    // the holder has had it, who won last, reported id, expected preempt.
    int m_holder = -1;
    int m_held   = 0;
    int m_last   = 1;
    int m_id     = 0;
    int m_pre    = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void m_grant(input int x);
        m_holder = x;
        m_held   = 1;
        m_last   = x;
        m_id     = x;
    endfunction

    always @(posedge clk) begin
        int k;
        int o;
        if (!reset) begin
            m_holder = -1; m_held = 0; m_last = 1; m_id = 0; m_pre = 0;
        end else begin
            m_pre = 0;
            if (m_holder < 0) begin
                if (req == 2'b11)  m_grant(1 - m_last);
                else if (req[0])   m_grant(0);
                else if (req[1])   m_grant(1);
            end else begin
                k = m_holder;
                o = 1 - k;
                if (done[k] || !req[k]) begin
                    if (req[o]) m_grant(o);
                    else        m_holder = -1;
                end else if (m_held >= MH && req[o]) begin
                    m_grant(o);
                    m_pre = 1;
                end else begin
                    m_held++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("gnt",       int'(gnt),       (m_holder < 0) ? 0 : (1 << m_holder));
            check("gnt_valid", int'(gnt_valid), (m_holder >= 0) ? 1 : 0);
            check("gnt_id",    int'(gnt_id),    m_id);
            check("preempt",   int'(preempt),   m_pre);
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0; req = 2'b00; done = 2'b00;
        step();
        reset = 1'b1;
    endtask

    // {req, done} pairs to exercise the model across mixed traffic.
    logic [3:0] vec [0:23] = '{
        4'b1100, 4'b1100, 4'b1100, 4'b1100, 4'b1100, 4'b1110,
        4'b1100, 4'b0100, 4'b0000, 4'b1000, 4'b1001, 4'b1000,
        4'b1100, 4'b1101, 4'b1100, 4'b1100, 4'b1100, 4'b1100,
        4'b1100, 4'b0111, 4'b0100, 4'b0101, 4'b0000, 4'b1100
    };

    initial begin
        step();
        chk_en = 1'b1;
        check("lit_rst_gnt",   int'(gnt),       0);
        check("lit_rst_valid", int'(gnt_valid), 0);
        check("lit_rst_id",    int'(gnt_id),    0);
        check("lit_rst_pre",   int'(preempt),   0);

        // Tie from reset: requester 0 first, forced handover after MH cycles.
        reset = 1'b1; req = 2'b11;
        step();
        check("lit_tie_gnt", int'(gnt), 1);
        check("lit_tie_id",  int'(gnt_id), 0);
        repeat (MH - 1) step();
        check("lit_hold_gnt", int'(gnt), 1);
        step();
        check("lit_force_gnt", int'(gnt), 2);
        check("lit_force_pre", int'(preempt), 1);
        step();
        check("lit_force_pre_drop", int'(preempt), 0);
        check("lit_force_gnt2",     int'(gnt), 2);

        // Normal handover at cycle 2 of GRANT0: no idle cycle, no preempt.
        do_reset(); req = 2'b11;
        step(); step();
        done = 2'b01;
        step();
        done = 2'b00;
        check("lit_norm_gnt", int'(gnt), 2);
        check("lit_norm_pre", int'(preempt), 0);

        // done and timeout at the same edge: normal release wins.
        do_reset(); req = 2'b11;
        step();
        repeat (MH - 1) step();
        done = 2'b01;
        step();
        done = 2'b00;
        check("lit_both_gnt", int'(gnt), 2);
        check("lit_both_pre", int'(preempt), 0);

        // Sole requester released: one idle cycle, then granted again.
        do_reset(); req = 2'b01;
        step();
        done = 2'b01;
        step();
        done = 2'b00;
        check("lit_sole_gap", int'(gnt), 0);
        check("lit_sole_id",  int'(gnt_id), 0);
        step();
        check("lit_sole_regrant", int'(gnt), 1);

        // Lone requester keeps the grant past MH with no preempt.
        do_reset(); req = 2'b01;
        for (int i = 0; i < 10; i++) begin
            step();
            check("lit_lone_gnt", int'(gnt), 1);
            check("lit_lone_pre", int'(preempt), 0);
        end

        // Tie after requester 0 won last goes to requester 1.
        do_reset(); req = 2'b01;
        step();
        req = 2'b00;
        step();
        req = 2'b11;
        step();
        check("lit_tie_last0", int'(gnt), 2);

        // Junk on the non-holder's done bit must not disturb GRANT1.
        do_reset(); req = 2'b10;
        step();
        done = 2'b0x;
        repeat (3) step();
        check("lit_xdone_gnt", int'(gnt), 2);
        done = 2'b00;

        // Reset during GRANT1 drops the grant; release with a tie gives 0.
        do_reset(); req = 2'b10;
        step();
        check("lit_g1_gnt", int'(gnt), 2);
        reset = 1'b0; req = 2'b11; done = 2'b10;
        step();
        check("lit_rst_g1_gnt", int'(gnt), 0);
        check("lit_rst_g1_id",  int'(gnt_id), 0);
        reset = 1'b1; done = 2'b00;
        step();
        check("lit_rel_gnt", int'(gnt), 1);

        // Mixed traffic checked against the model only.
        for (int i = 0; i < 24; i++) begin
            req  = vec[i][3:2];
            done = vec[i][1:0];
            step();
        end
        req = 2'b00; done = 2'b00;
        step(); step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
